// File: rtl/r88_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : r88_pkg                                                  |
// | Description : Shared definitions for the Rocket88 ALU sequencer:       |
// |               ALU op encodings, status-flag bit positions, sequencer   |
// |               state encoding and small op-classification helpers.     |
// | Ports       : none (package)                                           |
// | Config      : R88_BCD_EN is consumed by the modules, not the package.  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package r88_pkg;

   // ALU operation encodings
   localparam logic [2:0] R88_OP_PASS = 3'd0;
   localparam logic [2:0] R88_OP_SHL  = 3'd1;
   localparam logic [2:0] R88_OP_SHR  = 3'd2;
   localparam logic [2:0] R88_OP_ADD  = 3'd3;
   localparam logic [2:0] R88_OP_SUB  = 3'd4;
   localparam logic [2:0] R88_OP_OR   = 3'd5;
   localparam logic [2:0] R88_OP_AND  = 3'd6;
   localparam logic [2:0] R88_OP_XOR  = 3'd7;

   // Bit positions inside the {D,N,Z,C} flag vector
   localparam int unsigned R88_FLAG_C = 0;
   localparam int unsigned R88_FLAG_Z = 1;
   localparam int unsigned R88_FLAG_N = 2;
   localparam int unsigned R88_FLAG_D = 3;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_LATCH = 2'd2,
      ST_DRIVE = 2'd3
   } r88State_t;

   // Only add and subtract have a 16-bit left operand.
   function automatic logic isWideOp(input logic [2:0] op);
      return (op == R88_OP_ADD) || (op == R88_OP_SUB);
   endfunction

   // Shifts and arithmetic report a carry; pass and logic ops leave C alone.
   function automatic logic writesCarry(input logic [2:0] op);
      logic result;
      case (op)
         R88_OP_SHL, R88_OP_SHR, R88_OP_ADD, R88_OP_SUB: result = 1'b1;
         R88_OP_PASS, R88_OP_OR, R88_OP_AND, R88_OP_XOR: result = 1'b0;
         default:                                        result = 1'b0;
      endcase
      return result;
   endfunction

endpackage : r88_pkg
`default_nettype wire

// File: rtl/r88_alu_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : r88_alu_seq_if                                           |
// | Description : Bundle of request, flag-write, ALU control/feedback and  |
// |               result signals between the requester/ALU side (master)  |
// |               and the sequencer (slave).                               |
// | Ports       : request  - reqValid/reqReady/reqOp/reqWide/reqUseCarry/ |
// |                          reqInvert/reqRightBus                         |
// |               flags    - flagWe/flagIn, flags                          |
// |               ALU ctl  - aluOp/regLeft16/carryIn/invOut/decMode/       |
// |                          carryInEn/rightSel/aluResult/loadResult       |
// |               ALU in   - carryOut/highOut/busIn                        |
// |               result   - done/resultLo/resultHi                        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface r88_alu_seq_if;
   logic       reqValid;
   logic       reqReady;
   logic [2:0] reqOp;
   logic       reqWide;
   logic       reqUseCarry;
   logic       reqInvert;
   logic       reqRightBus;
   logic       flagWe;
   logic [3:0] flagIn;
   logic [2:0] aluOp;
   logic       regLeft16;
   logic       carryIn;
   logic       invOut;
   logic       decMode;
   logic       carryInEn;
   logic       rightSel;
   logic       aluResult;
   logic       loadResult;
   logic       carryOut;
   logic [7:0] highOut;
   logic [7:0] busIn;
   logic       done;
   logic [7:0] resultLo;
   logic [7:0] resultHi;
   logic [3:0] flags;

   modport master (
      output reqValid, reqOp, reqWide, reqUseCarry, reqInvert, reqRightBus,
      output flagWe, flagIn, carryOut, highOut, busIn,
      input  reqReady, aluOp, regLeft16, carryIn, invOut, decMode,
      input  carryInEn, rightSel, aluResult, loadResult,
      input  done, resultLo, resultHi, flags
   );

   modport slave (
      input  reqValid, reqOp, reqWide, reqUseCarry, reqInvert, reqRightBus,
      input  flagWe, flagIn, carryOut, highOut, busIn,
      output reqReady, aluOp, regLeft16, carryIn, invOut, decMode,
      output carryInEn, rightSel, aluResult, loadResult,
      output done, resultLo, resultHi, flags
   );
endinterface : r88_alu_seq_if
`default_nettype wire

// File: rtl/r88_flag_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : r88_flag_unit                                            |
// | Description : {D,N,Z,C} status register. Loads all flags from a direct |
// |               write strobe; at the end of an operation overwrites Z/N  |
// |               (and C for carry-producing ops) from the ALU result.     |
// | Ports       : sysClock, sysResetN (async, active-low)                  |
// |               flagWe/flagIn    direct write                            |
// |               opDone           last cycle of an operation (DRIVE)      |
// |               op/wideOp        operation in flight                     |
// |               carryOut/highOut/busIn  ALU result inputs                |
// |               flags            registered {D,N,Z,C}                    |
// | Config      : R88_BCD_EN defined -> D is a writable flag;              |
// |               undefined -> D is held at 0 and flagIn[3] is ignored.    |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module r88_flag_unit
   import r88_pkg::*;
(
   input  wire logic       sysClock,
   input  wire logic       sysResetN,
   input  wire logic       flagWe,
   input  wire logic [3:0] flagIn,
   input  wire logic       opDone,
   input  wire logic [2:0] op,
   input  wire logic       wideOp,
   input  wire logic       carryOut,
   input  wire logic [7:0] highOut,
   input  wire logic [7:0] busIn,
   output logic      [3:0] flags
);

   logic [3:0] r_flags;
   logic [3:0] w_flagsNext;
   logic [3:0] w_flagInMasked;

`ifdef R88_BCD_EN
   assign w_flagInMasked = flagIn;
`else
   // D does not exist in this build; the write value for it is dropped.
   logic w_unusedBcdIn;
   assign w_unusedBcdIn  = flagIn[R88_FLAG_D];
   assign w_flagInMasked = {1'b0, flagIn[2:0]};
`endif

   // The operation's C/Z/N are applied after the direct write so that they
   // take priority on a collision; D only ever comes from the direct write.
   always_comb begin
      w_flagsNext = r_flags;
      if (flagWe) begin
         w_flagsNext = w_flagInMasked;
      end
      if (opDone) begin
         if (writesCarry(op)) begin
            w_flagsNext[R88_FLAG_C] = carryOut;
         end
         w_flagsNext[R88_FLAG_Z] = wideOp ? ({highOut, busIn} == 16'h0000)
                                          : (busIn == 8'h00);
         w_flagsNext[R88_FLAG_N] = wideOp ? highOut[7] : busIn[7];
      end
   end

   always_ff @(posedge sysClock or negedge sysResetN) begin
      if (!sysResetN) begin
         r_flags <= 4'h0;
      end else begin
         r_flags <= w_flagsNext;
      end
   end

   assign flags = r_flags;

endmodule : r88_flag_unit
`default_nettype wire

// File: rtl/r88_alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : r88_alu_seq                                              |
// | Description : Rocket88 ALU sequencer. Accepts one request per          |
// |               handshake, steps the ALU through EXEC/LATCH/DRIVE,       |
// |               captures the result and updates the status flags.        |
// | Ports       : sysClock   system clock (rising edge)                    |
// |               sysResetN  asynchronous active-low reset                 |
// |               bus        r88_alu_seq_if.slave (request, ALU controls,  |
// |                          ALU feedback, results, flags)                 |
// | Config      : R88_BCD_EN defined -> decMode follows the D flag;        |
// |               undefined -> decMode is tied to 0.                       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module r88_alu_seq
   import r88_pkg::*;
(
   input  wire logic    sysClock,
   input  wire logic    sysResetN,
   r88_alu_seq_if.slave bus
);

   r88State_t  r_state;
   logic [2:0] r_aluOp;
   logic       r_regLeft16;
   logic       r_carryInEn;
   logic       r_rightSel;
   logic       r_invOut;
   logic       r_loadResult;
   logic       r_aluResult;
   logic       r_done;
   logic [7:0] r_resultLo;
   logic [7:0] r_resultHi;
   logic [3:0] w_flags;

   // Control outputs are registered: they are loaded on accept, held through
   // DRIVE and cleared on the way back to IDLE. The strobes are set one state
   // ahead so they are high exactly during LATCH and DRIVE respectively.
   always_ff @(posedge sysClock or negedge sysResetN) begin
      if (!sysResetN) begin
         r_state      <= ST_IDLE;
         r_aluOp      <= 3'd0;
         r_regLeft16  <= 1'b0;
         r_carryInEn  <= 1'b0;
         r_rightSel   <= 1'b0;
         r_invOut     <= 1'b0;
         r_loadResult <= 1'b0;
         r_aluResult  <= 1'b0;
         r_done       <= 1'b0;
         r_resultLo   <= 8'h00;
         r_resultHi   <= 8'h00;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.reqValid) begin
                  r_state     <= ST_EXEC;
                  r_aluOp     <= bus.reqOp;
                  // The wide operand is only meaningful for add/sub.
                  r_regLeft16 <= bus.reqWide & isWideOp(bus.reqOp);
                  r_carryInEn <= bus.reqUseCarry;
                  r_rightSel  <= bus.reqRightBus;
                  r_invOut    <= bus.reqInvert;
               end
            end
            ST_EXEC: begin
               r_state      <= ST_LATCH;
               r_loadResult <= 1'b1;
            end
            ST_LATCH: begin
               r_state      <= ST_DRIVE;
               r_loadResult <= 1'b0;
               r_aluResult  <= 1'b1;
            end
            ST_DRIVE: begin
               r_state     <= ST_IDLE;
               r_aluResult <= 1'b0;
               r_aluOp     <= 3'd0;
               r_regLeft16 <= 1'b0;
               r_carryInEn <= 1'b0;
               r_rightSel  <= 1'b0;
               r_invOut    <= 1'b0;
               r_done      <= 1'b1;
               r_resultLo  <= bus.busIn;
               r_resultHi  <= r_regLeft16 ? bus.highOut : 8'h00;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Flag update uses the still-held request registers during DRIVE.
   r88_flag_unit u_flagUnit (
      .sysClock  (sysClock),
      .sysResetN (sysResetN),
      .flagWe    (bus.flagWe),
      .flagIn    (bus.flagIn),
      .opDone    (r_state == ST_DRIVE),
      .op        (r_aluOp),
      .wideOp    (r_regLeft16),
      .carryOut  (bus.carryOut),
      .highOut   (bus.highOut),
      .busIn     (bus.busIn),
      .flags     (w_flags)
   );

   assign bus.reqReady   = (r_state == ST_IDLE);
   assign bus.aluOp      = r_aluOp;
   assign bus.regLeft16  = r_regLeft16;
   assign bus.carryInEn  = r_carryInEn;
   assign bus.rightSel   = r_rightSel;
   assign bus.invOut     = r_invOut;
   assign bus.loadResult = r_loadResult;
   assign bus.aluResult  = r_aluResult;
   assign bus.carryIn    = w_flags[R88_FLAG_C];
`ifdef R88_BCD_EN
   assign bus.decMode    = w_flags[R88_FLAG_D];
`else
   assign bus.decMode    = 1'b0;
`endif
   assign bus.done       = r_done;
   assign bus.resultLo   = r_resultLo;
   assign bus.resultHi   = r_resultHi;
   assign bus.flags      = w_flags;

endmodule : r88_alu_seq
`default_nettype wire

// File: tb/tb_r88_alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_r88_alu_seq                                           |
// | Description : Self-checking bench for r88_alu_seq: directed vector     |
// |               table, reset/flag-write/back-to-back sequences and       |
// |               random operations against a flag/result reference model. |
// | Config      : honours R88_BCD_EN like the design.                      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_r88_alu_seq;

   logic sysClock = 1'b0;
   logic sysResetN = 1'b0;
   always #5 sysClock = ~sysClock;

   r88_alu_seq_if ifc ();

   r88_alu_seq dut (
      .sysClock  (sysClock),
      .sysResetN (sysResetN),
      .bus       (ifc)
   );

`ifdef R88_BCD_EN
   localparam bit c_BCD = 1'b1;
`else
   localparam bit c_BCD = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   logic [3:0] mFlags;   // reference {D,N,Z,C}

   typedef struct {
      logic [2:0] op;
      bit         wide, useC, inv, rb;
      logic [7:0] bus, high;
      bit         cout, fwe;
      logic [3:0] fIn;
      logic [7:0] expLo, expHi;
      logic [3:0] expFlags;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] maskD(input logic [3:0] f);
      return c_BCD ? f : {1'b0, f[2:0]};
   endfunction

   // Runs one full operation, checks the control outputs phase by phase and
   // the captured results/flags against the reference model.
   task automatic doOp(input logic [2:0] op, input bit wide, input bit useC,
                       input bit inv, input bit rb, input logic [7:0] busV,
                       input logic [7:0] highV, input bit cout, input bit fwe,
                       input logic [3:0] fIn);
      bit expWide;
      int n;
      expWide = wide && (op == 3'd3 || op == 3'd4);
      n = 0;
      while (ifc.reqReady !== 1'b1 && n < 10) begin
         @(negedge sysClock);
         n++;
      end
      chk("ready_before_req", 16'(ifc.reqReady), 16'd1);
      ifc.reqValid = 1'b1; ifc.reqOp = op; ifc.reqWide = wide;
      ifc.reqUseCarry = useC; ifc.reqInvert = inv; ifc.reqRightBus = rb;
      @(negedge sysClock);  // EXEC
      ifc.reqValid = 1'b0;
      // scramble request fields: the sequencer must hold its own copy
      ifc.reqOp = ~op; ifc.reqWide = ~wide; ifc.reqUseCarry = ~useC;
      ifc.reqInvert = ~inv; ifc.reqRightBus = ~rb;
      chk("exec_aluOp", 16'(ifc.aluOp), 16'(op));
      chk("exec_regLeft16", 16'(ifc.regLeft16), 16'(expWide));
      chk("exec_ctrl{cie,rs,inv}", 16'({ifc.carryInEn, ifc.rightSel, ifc.invOut}),
          16'({useC, rb, inv}));
      chk("exec_strobes{ld,res,done,rdy}",
          16'({ifc.loadResult, ifc.aluResult, ifc.done, ifc.reqReady}), 16'd0);
      chk("exec_carryIn", 16'(ifc.carryIn), 16'(mFlags[0]));
      chk("exec_decMode", 16'(ifc.decMode), 16'(mFlags[3]));
      @(negedge sysClock);  // LATCH
      chk("latch_strobes{ld,res}", 16'({ifc.loadResult, ifc.aluResult}), 16'b10);
      chk("latch_ctrl{op,w}", 16'({ifc.aluOp, ifc.regLeft16}), 16'({op, expWide}));
      @(negedge sysClock);  // DRIVE
      chk("drive_strobes{ld,res}", 16'({ifc.loadResult, ifc.aluResult}), 16'b01);
      chk("drive_ctrl{op,w,cie,rs,inv}",
          16'({ifc.aluOp, ifc.regLeft16, ifc.carryInEn, ifc.rightSel, ifc.invOut}),
          16'({op, expWide, useC, rb, inv}));
      ifc.busIn = busV; ifc.highOut = highV; ifc.carryOut = cout;
      ifc.flagWe = fwe; ifc.flagIn = fIn;
      // reference model: direct write first, then the operation's C/Z/N
      if (fwe) mFlags = maskD(fIn);
      if (op >= 3'd1 && op <= 3'd4) mFlags[0] = cout;
      mFlags[1] = expWide ? ({highV, busV} == 16'h0000) : (busV == 8'h00);
      mFlags[2] = expWide ? highV[7] : busV[7];
      @(negedge sysClock);  // k+4
      ifc.flagWe = 1'b0;
      chk("done_pulse", 16'(ifc.done), 16'd1);
      chk("resultLo", 16'(ifc.resultLo), 16'(busV));
      chk("resultHi", 16'(ifc.resultHi), expWide ? 16'(highV) : 16'd0);
      chk("flags", 16'(ifc.flags), 16'(mFlags));
      chk("idle_ready", 16'(ifc.reqReady), 16'd1);
      chk("idle_ctrl_zero",
          16'({ifc.aluOp, ifc.regLeft16, ifc.carryInEn, ifc.rightSel, ifc.invOut,
               ifc.loadResult, ifc.aluResult}), 16'd0);
      ifc.busIn = 8'($urandom); ifc.highOut = 8'($urandom); ifc.carryOut = 1'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int accepts, loads, results, dones, firstAcc, lastAcc, doneSeen;
      ifc.reqValid = 0; ifc.reqOp = 0; ifc.reqWide = 0; ifc.reqUseCarry = 0;
      ifc.reqInvert = 0; ifc.reqRightBus = 0; ifc.flagWe = 0; ifc.flagIn = 0;
      ifc.carryOut = 0; ifc.highOut = 0; ifc.busIn = 0;
      mFlags = 4'h0;

      //         op   w useC inv rb  bus    high   co fwe fIn      lo     hi     flags
      vecs[0] = '{3'd3, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 4'h0,    8'h00, 8'h00, 4'b0011};
      vecs[1] = '{3'd4, 1, 1, 0, 1, 8'h01, 8'h80, 0, 0, 4'h0,    8'h01, 8'h80, 4'b0100};
      vecs[2] = '{3'd1, 0, 0, 0, 0, 8'h02, 8'h33, 0, 1, 4'hF,    8'h02, 8'h00, 4'b1000};
      vecs[3] = '{3'd3, 0, 1, 1, 0, 8'hFE, 8'h00, 1, 0, 4'h0,    8'hFE, 8'h00, 4'b1101};
      vecs[4] = '{3'd5, 1, 0, 0, 1, 8'h00, 8'h55, 0, 0, 4'h0,    8'h00, 8'h00, 4'b1011};
      vecs[5] = '{3'd7, 0, 0, 0, 0, 8'h80, 8'h00, 1, 1, 4'b0010, 8'h80, 8'h00, 4'b0100};
      vecs[6] = '{3'd2, 1, 1, 1, 1, 8'h00, 8'hFF, 1, 0, 4'h0,    8'h00, 8'h00, 4'b0011};
      vecs[7] = '{3'd4, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 4'h0,    8'h00, 8'h00, 4'b0011};
      vecs[8] = '{3'd0, 0, 0, 0, 0, 8'h7F, 8'h00, 1, 0, 4'h0,    8'h7F, 8'h00, 4'b0001};
      vecs[9] = '{3'd6, 1, 0, 0, 0, 8'h00, 8'h12, 0, 0, 4'h0,    8'h00, 8'h00, 4'b0011};

      // reset state
      #1;
      chk("reset_outputs",
          16'({ifc.aluOp, ifc.regLeft16, ifc.carryIn, ifc.invOut, ifc.decMode,
               ifc.carryInEn, ifc.rightSel, ifc.aluResult, ifc.loadResult, ifc.done}), 16'd0);
      chk("reset_results_flags", {ifc.resultLo, ifc.resultHi} | 16'(ifc.flags), 16'd0);
      chk("reset_ready", 16'(ifc.reqReady), 16'd1);
      repeat (2) @(negedge sysClock);
      sysResetN = 1'b1;
      @(negedge sysClock);

      // directed vector table
      for (int i = 0; i < 10; i++) begin
         doOp(vecs[i].op, vecs[i].wide, vecs[i].useC, vecs[i].inv, vecs[i].rb,
              vecs[i].bus, vecs[i].high, vecs[i].cout, vecs[i].fwe, vecs[i].fIn);
         chk($sformatf("vec%0d_lo", i), 16'(ifc.resultLo), 16'(vecs[i].expLo));
         chk($sformatf("vec%0d_hi", i), 16'(ifc.resultHi), 16'(vecs[i].expHi));
         chk($sformatf("vec%0d_flags", i), 16'(ifc.flags), 16'(maskD(vecs[i].expFlags)));
      end

      // direct flag write while idle
      ifc.flagWe = 1'b1; ifc.flagIn = 4'b1010;
      @(negedge sysClock);
      ifc.flagWe = 1'b0;
      mFlags = maskD(4'b1010);
      chk("idle_flagWe", 16'(ifc.flags), 16'(mFlags));
      chk("idle_decMode", 16'(ifc.decMode), 16'(mFlags[3]));

      // reset in the middle of EXEC
      ifc.reqValid = 1'b1; ifc.reqOp = 3'd3; ifc.reqWide = 1'b1; ifc.reqUseCarry = 1'b1;
      @(negedge sysClock);
      ifc.reqValid = 1'b0;
      chk("midreset_in_exec", 16'(ifc.regLeft16), 16'd1);
      #2 sysResetN = 1'b0;
      #1;
      chk("midreset_ctrl",
          16'({ifc.aluOp, ifc.regLeft16, ifc.carryIn, ifc.invOut, ifc.decMode,
               ifc.carryInEn, ifc.rightSel, ifc.aluResult, ifc.loadResult, ifc.done}), 16'd0);
      chk("midreset_results", {ifc.resultLo, ifc.resultHi}, 16'd0);
      chk("midreset_flags", 16'(ifc.flags), 16'd0);
      chk("midreset_ready", 16'(ifc.reqReady), 16'd1);
      mFlags = 4'h0;
      @(negedge sysClock);
      sysResetN = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge sysClock);
         if (ifc.done) doneSeen++;
      end
      chk("midreset_no_done", 16'(doneSeen), 16'd0);

      // back-to-back with reqValid held high
      ifc.reqValid = 1'b1; ifc.reqOp = 3'd0; ifc.reqWide = 1'b0; ifc.reqUseCarry = 1'b0;
      ifc.busIn = 8'h01; ifc.highOut = 8'h00; ifc.carryOut = 1'b0;
      accepts = 0; loads = 0; results = 0; dones = 0; firstAcc = -1; lastAcc = -1;
      for (int i = 0; i < 16; i++) begin
         if (i == 12) ifc.reqValid = 1'b0;
         if (ifc.reqValid && ifc.reqReady) begin
            accepts++;
            if (firstAcc < 0) firstAcc = i;
            lastAcc = i;
         end
         if (ifc.loadResult) loads++;
         if (ifc.aluResult) results++;
         if (ifc.done) dones++;
         @(negedge sysClock);
      end
      mFlags[1] = 1'b0; mFlags[2] = 1'b0;
      chk("b2b_accepts", 16'(accepts), 16'd3);
      chk("b2b_spacing", 16'(lastAcc - firstAcc), 16'd8);
      chk("b2b_loadResult", 16'(loads), 16'd3);
      chk("b2b_aluResult", 16'(results), 16'd3);
      chk("b2b_done", 16'(dones), 16'd3);
      chk("b2b_flags", 16'(ifc.flags), 16'(mFlags));

      // random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         doOp(3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
              8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
              1'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_r88_alu_seq
`default_nettype wire
